// File: rtl/write_back_pkg.sv
// Shared CPU package: datapath defaults and the MemToReg select encoding
// used by the write-back stage.
package write_back_pkg;

    localparam int unsigned DATA_W_DEF   = 64;  // read-data / ALU-result width
    localparam int unsigned REG_AW_DEF   = 5;   // register-address width
    localparam int unsigned ZERO_REG_DEF = 31;  // XZR index, never written

    // MemToReg select encoding
    typedef enum logic {
        SEL_ALU = 1'b0,
        SEL_MEM = 1'b1
    } mem_sel_e;

endpackage : write_back_pkg

// File: rtl/write_back.sv
// Write-back stage: selects memory data or ALU result and registers it,
// together with the destination index and a write enable that is
// suppressed for the hard-wired zero register.
//
// Ports:
//   clk          - clock, all state updates on rising edge
//   reset        - asynchronous active-high reset, clears all outputs
//   WriteReg     - destination register index
//   ReadData     - data loaded from data memory
//   ALUResult    - ALU result / effective address
//   MemToReg     - 1 selects ReadData, 0 selects ALUResult
//   RegWrite     - register-file write request
//   Data2Write   - registered write data
//   Reg2Write    - registered write index
//   oldRegWrite  - registered, qualified write enable
module write_back #(
    parameter int unsigned DATA_W   = write_back_pkg::DATA_W_DEF,
    parameter int unsigned REG_AW   = write_back_pkg::REG_AW_DEF,
    parameter int unsigned ZERO_REG = write_back_pkg::ZERO_REG_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] WriteReg,
    input  logic [DATA_W-1:0] ReadData,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic              MemToReg,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] Data2Write,
    output logic [REG_AW-1:0] Reg2Write,
    output logic              oldRegWrite
);

    import write_back_pkg::*;

    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

    mem_sel_e          sel;
    logic [DATA_W-1:0] wb_data;
    logic              wb_en;

    always_comb begin
        sel     = mem_sel_e'(MemToReg);
        wb_data = (sel == SEL_MEM) ? ReadData : ALUResult;
        // Writes to XZR are dropped here; data and index still flow through.
        wb_en   = RegWrite && (WriteReg != ZERO_IDX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Data2Write  <= '0;
            Reg2Write   <= '0;
            oldRegWrite <= 1'b0;
        end else begin
            Data2Write  <= wb_data;
            Reg2Write   <= WriteReg;
            oldRegWrite <= wb_en;
        end
    end

endmodule : write_back

// File: tb/tb_write_back.sv
// Directed self-checking bench for the write-back stage.
module tb_write_back;

    logic        clk;
    logic        reset;
    logic [4:0]  WriteReg;
    logic [63:0] ReadData;
    logic [63:0] ALUResult;
    logic        MemToReg;
    logic        RegWrite;
    logic [63:0] Data2Write;
    logic [4:0]  Reg2Write;
    logic        oldRegWrite;

    int vectors;
    int miscompares;

    write_back #(
        .DATA_W   (64),
        .REG_AW   (5),
        .ZERO_REG (31)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .WriteReg    (WriteReg),
        .ReadData    (ReadData),
        .ALUResult   (ALUResult),
        .MemToReg    (MemToReg),
        .RegWrite    (RegWrite),
        .Data2Write  (Data2Write),
        .Reg2Write   (Reg2Write),
        .oldRegWrite (oldRegWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] wr, input logic [63:0] rd,
                         input logic [63:0] alu, input logic m2r,
                         input logic rw);
        WriteReg  = wr;
        ReadData  = rd;
        ALUResult = alu;
        MemToReg  = m2r;
        RegWrite  = rw;
    endtask

    task automatic test_reset();
        // Reset is high from time 0; check before any rising edge.
        #2;
        vectors++;
        if (Data2Write !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected %h", Data2Write, 64'h0);
        end
        vectors++;
        if (Reg2Write !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_reg: got %0d expected 0", Reg2Write);
        end
        vectors++;
        if (oldRegWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_we: got %b expected 0", oldRegWrite);
        end
        // Random inputs across edges while reset held: outputs stay zero.
        for (int i = 0; i < 4; i++) begin
            drive(5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom), 1'b1);
            tick();
            vectors++;
            if (Data2Write !== 64'h0 || Reg2Write !== 5'd0 || oldRegWrite !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold: got %h/%0d/%b expected 0/0/0",
                         Data2Write, Reg2Write, oldRegWrite);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu_select();
        @(negedge clk);
        drive(5'd5, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_002A, 1'b0, 1'b1);
        tick();
        vectors++;
        if (Data2Write !== 64'h2A) begin
            miscompares++;
            $display("FAIL alu_data: got %h expected %h", Data2Write, 64'h2A);
        end
        vectors++;
        if (Reg2Write !== 5'd5) begin
            miscompares++;
            $display("FAIL alu_reg: got %0d expected 5", Reg2Write);
        end
        vectors++;
        if (oldRegWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL alu_we: got %b expected 1", oldRegWrite);
        end
    endtask

    task automatic test_mem_select();
        @(negedge clk);
        drive(5'd5, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_002A, 1'b1, 1'b1);
        tick();
        vectors++;
        if (Data2Write !== 64'hDEAD_BEEF_0000_0001) begin
            miscompares++;
            $display("FAIL mem_data: got %h expected %h", Data2Write,
                     64'hDEAD_BEEF_0000_0001);
        end
        vectors++;
        if (Reg2Write !== 5'd5 || oldRegWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL mem_ctrl: got %0d/%b expected 5/1", Reg2Write, oldRegWrite);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        drive(5'd31, 64'h0, 64'h7, 1'b0, 1'b1);
        tick();
        vectors++;
        if (oldRegWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL xzr_we: got %b expected 0", oldRegWrite);
        end
        vectors++;
        if (Reg2Write !== 5'd31 || Data2Write !== 64'h7) begin
            miscompares++;
            $display("FAIL xzr_pass: got %0d/%h expected 31/%h", Reg2Write,
                     Data2Write, 64'h7);
        end
        // Register 30 is an ordinary register and must be writable.
        @(negedge clk);
        drive(5'd30, 64'h0, 64'h8, 1'b0, 1'b1);
        tick();
        vectors++;
        if (oldRegWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL r30_we: got %b expected 1", oldRegWrite);
        end
    endtask

    task automatic test_no_write();
        @(negedge clk);
        drive(5'd9, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        tick();
        vectors++;
        if (oldRegWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL nowr_we: got %b expected 0", oldRegWrite);
        end
        vectors++;
        if (Data2Write !== 64'hFFFF_FFFF_FFFF_FFFF || Reg2Write !== 5'd9) begin
            miscompares++;
            $display("FAIL nowr_pass: got %h/%0d expected %h/9", Data2Write,
                     Reg2Write, 64'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] vals [3];
        vals[0] = 64'd10;
        vals[1] = 64'd20;
        vals[2] = 64'd30;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(5'(i + 1), 64'h0, vals[i], 1'b0, 1'b1);
            // New inputs must not reach the outputs before the edge.
            #1;
            if (i > 0) begin
                vectors++;
                if (Reg2Write !== 5'(i) || Data2Write !== vals[i-1]) begin
                    miscompares++;
                    $display("FAIL b2b_hold%0d: got %0d/%0d expected %0d/%0d", i,
                             Reg2Write, Data2Write, i, vals[i-1]);
                end
            end
            tick();
            vectors++;
            if (Reg2Write !== 5'(i + 1) || Data2Write !== vals[i] || oldRegWrite !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_out%0d: got %0d/%0d/%b expected %0d/%0d/1", i,
                         Reg2Write, Data2Write, oldRegWrite, i + 1, vals[i]);
            end
        end
        // Assert reset between edges: outputs clear without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (Data2Write !== 64'h0 || Reg2Write !== 5'd0 || oldRegWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset: got %h/%0d/%b expected 0/0/0", Data2Write,
                     Reg2Write, oldRegWrite);
        end
        // First edge after release captures the inputs present at that edge.
        @(negedge clk);
        reset = 1'b0;
        drive(5'd12, 64'hA5A5_0000_5A5A_FFFF, 64'h1, 1'b1, 1'b1);
        tick();
        vectors++;
        if (Data2Write !== 64'hA5A5_0000_5A5A_FFFF || Reg2Write !== 5'd12 || oldRegWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL postreset: got %h/%0d/%b expected %h/12/1", Data2Write,
                     Reg2Write, oldRegWrite, 64'hA5A5_0000_5A5A_FFFF);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        drive(5'd0, 64'h0, 64'h0, 1'b0, 1'b0);
        test_reset();
        test_alu_select();
        test_mem_select();
        test_zero_reg();
        test_no_write();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_write_back
